// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//   Philips-format I2S slave receiver for a single channel. The bit clock,
//   word select and serial data arrive asynchronously and are oversampled in
//   the clk_i domain. One slot (left or right, chosen by CHANNEL) is captured
//   MSB first and presented as a DWIDTH-bit two's-complement sample.
//
// Parameters
//   DWIDTH  : output sample width in bits (>= 2)
//   CHANNEL : captured slot, 0 = left (ws low), 1 = right (ws high)
//
// Ports
//   clk_i         : system clock
//   rst_ni        : asynchronous active-low reset
//   sck_i         : I2S bit clock (asynchronous, period >= 8 clk_i)
//   ws_i          : I2S word select (asynchronous)
//   sd_i          : I2S serial data, MSB first (asynchronous)
//   data_o        : last complete sample, held between ticks
//   sample_tick_o : one-cycle pulse when data_o takes a new value
//   short_err_o   : one-cycle pulse (with the tick) when the slot was short
// ---------------------------------------------------------------------------
module i2s_receiver #(
    parameter int DWIDTH  = 16,
    parameter bit CHANNEL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sample_tick_o,
    output logic              short_err_o
);

    localparam int CW = $clog2(DWIDTH + 1);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_SLOT,
        CAPTURE,
        SKIP
    } state_e;

    // [0],[1] form the synchronizer; sck gets a third stage for edge detection
    logic [2:0]        sck_sync_q;
    logic [1:0]        ws_sync_q;
    logic [1:0]        sd_sync_q;

    logic              ws_prev_q;
    logic              ws_seen_q;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic              emit_q, emit_d;
    logic              short_q, short_d;
    logic [DWIDTH-1:0] word_q, word_d;

    logic              bit_ev;
    logic              ws_now;
    logic              sd_now;
    logic              ws_chg;
    logic [DWIDTH-1:0] shifted;
    logic [CW-1:0]     cnt_inc;

    assign bit_ev  = sck_sync_q[1] & ~sck_sync_q[2];
    assign ws_now  = ws_sync_q[1];
    assign sd_now  = sd_sync_q[1];
    // The very first bit event after reset only records ws; it cannot be a change.
    assign ws_chg  = bit_ev & ws_seen_q & (ws_now != ws_prev_q);
    assign shifted = {shreg_q[DWIDTH-2:0], sd_now};
    assign cnt_inc = (cnt_q == CW'(DWIDTH)) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q    <= '0;
            ws_sync_q     <= '0;
            sd_sync_q     <= '0;
            ws_prev_q     <= 1'b0;
            ws_seen_q     <= 1'b0;
            state_q       <= SYNC;
            cnt_q         <= '0;
            shreg_q       <= '0;
            emit_q        <= 1'b0;
            short_q       <= 1'b0;
            word_q        <= '0;
            data_o        <= '0;
            sample_tick_o <= 1'b0;
            short_err_o   <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck_i};
            ws_sync_q  <= {ws_sync_q[0], ws_i};
            sd_sync_q  <= {sd_sync_q[0], sd_i};
            if (bit_ev) begin
                ws_prev_q <= ws_now;
                ws_seen_q <= 1'b1;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            emit_q  <= emit_d;
            short_q <= short_d;
            word_q  <= word_d;
            // Second register stage: outputs appear two cycles after the event.
            sample_tick_o <= emit_q;
            short_err_o   <= emit_q & short_q;
            if (emit_q) begin
                data_o <= word_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        emit_d  = 1'b0;
        short_d = 1'b0;
        word_d  = word_q;
        case (state_q)
            SYNC: begin
                if (ws_chg) begin
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                // ws change marks the previous slot's LSB; our MSB follows.
                if (ws_chg && (ws_now == CHANNEL)) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bit_ev) begin
                    // The bit carried by the ws-change event is this slot's LSB.
                    shreg_d = shifted;
                    cnt_d   = cnt_inc;
                    if (ws_chg) begin
                        emit_d  = 1'b1;
                        short_d = (cnt_inc < CW'(DWIDTH));
                        word_d  = shifted << (CW'(DWIDTH) - cnt_inc);
                        state_d = WAIT_SLOT;
                    end else if (cnt_inc == CW'(DWIDTH)) begin
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (ws_chg) begin
                    emit_d  = 1'b1;
                    word_d  = shreg_q;
                    state_d = WAIT_SLOT;
                end
            end
            default: state_d = SYNC;
        endcase
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//   Three receivers share one I2S bus: 16-bit left, 16-bit right and 24-bit
//   left. Streams are described as lists of slots; expected samples are
//   derived from the slot list and queued per receiver, and a monitor on the
//   falling clk edge pops and compares whenever a receiver ticks.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

    typedef struct {
        logic [23:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        ws = 1'b1;
    logic        sd = 1'b0;
    logic [15:0] d0, d1;
    logic [23:0] d2;
    logic        t0, t1, t2, e0, e1, e2;

    exp_t        expq[3][$];
    int          total = 0;
    int          bad = 0;
    int          dut_dw[3] = '{16, 16, 24};
    int          dut_ch[3] = '{0, 1, 0};

    logic [31:0] slot_val[$];
    int          slot_len[$];
    int          slot_lvl[$];
    int          rst_slot = -1;
    bit          jit_on = 1'b0;
    longint      tick_t[$];

    logic [23:0] prev_d[3] = '{default: '0};
    logic        prev_t[3] = '{default: 1'b0};

    always #5 clk = ~clk;

    i2s_receiver #(.DWIDTH(16), .CHANNEL(1'b0)) u_l16 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .data_o(d0), .sample_tick_o(t0), .short_err_o(e0)
    );
    i2s_receiver #(.DWIDTH(16), .CHANNEL(1'b1)) u_r16 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .data_o(d1), .sample_tick_o(t1), .short_err_o(e1)
    );
    i2s_receiver #(.DWIDTH(24), .CHANNEL(1'b0)) u_l24 (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .ws_i(ws), .sd_i(sd),
        .data_o(d2), .sample_tick_o(t2), .short_err_o(e2)
    );

    // Reference: first min(n,dw) bits of an n-bit MSB-first slot, zero-filled.
    function automatic logic [23:0] exp_word(input logic [31:0] v, input int n, input int dw);
        longint unsigned w;
        w = 64'(v) & ((64'd1 << n) - 64'd1);
        if (n >= dw) w = w >> (n - dw);
        else         w = w << (dw - n);
        w = w & ((64'd1 << dw) - 64'd1);
        return w[23:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic mon(input int i, input logic [23:0] d, input logic t, input logic e);
        exp_t x;
        if (t) begin
            total++;
            if (prev_t[i]) begin
                bad++;
                $display("FAIL tick_pulse dut%0d: tick high two cycles running, required single pulse", i);
            end
            if (expq[i].size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick dut%0d: data=%h err=%b, required no tick", i, d, e);
            end else begin
                x = expq[i].pop_front();
                if (d !== x.data || e !== x.err) begin
                    bad++;
                    $display("FAIL sample dut%0d: got data=%h err=%b, required data=%h err=%b",
                             i, d, e, x.data, x.err);
                end
            end
            if (i == 0 && jit_on) tick_t.push_back($time);
        end else if (rst_n) begin
            if (e !== 1'b0 || d !== prev_d[i]) begin
                total++;
                bad++;
                $display("FAIL idle_hold dut%0d: data=%h err=%b without tick, required data=%h err=0",
                         i, d, e, prev_d[i]);
            end
        end
        prev_d[i] = d;
        prev_t[i] = t;
    endtask

    always @(negedge clk) begin
        mon(0, {8'h00, d0}, t0, e0);
        mon(1, {8'h00, d1}, t1, e1);
        mon(2, d2, t2, e2);
    end

    task automatic add_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv, input int rn);
        slot_val.push_back(lv); slot_len.push_back(ln); slot_lvl.push_back(0);
        slot_val.push_back(rv); slot_len.push_back(rn); slot_lvl.push_back(1);
    endtask

    task automatic run_stream(input string name);
        logic sdb[$];
        int   lvl[$];
        int   rst_bit;
        int   jp, jn, low;
        exp_t x;
        longint diff;
        rst_bit = -1;

        rst_n = 1'b0; sck = 1'b0; ws = 1'b1; sd = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Slot 0 begins at the first ws change (sync only); a reset also
        // drops the interrupted slot and the slot starting at the next change.
        for (int i = 0; i < slot_val.size(); i++) begin
            for (int k = 0; k < 3; k++) begin
                if (slot_lvl[i] == dut_ch[k] && i != 0 &&
                    !(rst_slot >= 0 && (i == rst_slot || i == rst_slot + 1))) begin
                    x.data = exp_word(slot_val[i], slot_len[i], dut_dw[k]);
                    x.err  = (slot_len[i] < dut_dw[k]);
                    expq[k].push_back(x);
                end
            end
        end

        for (int b = 0; b < 2; b++) begin sdb.push_back(1'b0); lvl.push_back(1); end
        for (int i = 0; i < slot_val.size(); i++) begin
            if (i == rst_slot) rst_bit = sdb.size() + 7;
            for (int j = 0; j < slot_len[i]; j++) begin
                sdb.push_back(slot_val[i][slot_len[i]-1-j]);
                lvl.push_back(slot_lvl[i]);
            end
        end
        for (int b = 0; b < 2; b++) begin sdb.push_back(1'b0); lvl.push_back(0); end

        @(posedge clk); #5;
        jp = 0;
        for (int b = 0; b < sdb.size(); b++) begin
            jn  = jit_on ? int'($urandom_range(2)) - 1 : 0;
            low = 40 + 10 * (jn - jp);
            jp  = jn;
            sck = 1'b0;
            sd  = sdb[b];
            // Philips: ws leads the slot by one bit.
            ws  = (b + 1 < sdb.size()) ? (lvl[b+1] != 0) : (lvl[b] != 0);
            #(low);
            sck = 1'b1;
            if (b == rst_bit) begin
                #10;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_data0", {16'h0, d0}, 32'h0);
                chk("rst_mid_data1", {16'h0, d1}, 32'h0);
                chk("rst_mid_data2", {8'h0, d2}, 32'h0);
                chk("rst_mid_ticks", {29'h0, t0, t1, t2}, 32'h0);
                #49;
                rst_n = 1'b1;
                #30;
            end else begin
                #40;
            end
        end
        sck = 1'b0;
        repeat (40) @(posedge clk);

        for (int k = 0; k < 3; k++) begin
            total++;
            if (expq[k].size() != 0) begin
                bad++;
                $display("FAIL %s_missing dut%0d: %0d samples outstanding, required 0",
                         name, k, expq[k].size());
            end
            expq[k].delete();
        end

        if (jit_on) begin
            for (int i = 1; i < tick_t.size(); i++) begin
                diff = tick_t[i] - tick_t[i-1];
                total++;
                if (diff < 5100 || diff > 5140) begin
                    bad++;
                    $display("FAIL tick_spacing #%0d: got %0d time units, required 5120 +-20", i, diff);
                end
            end
        end

        slot_val.delete(); slot_len.delete(); slot_lvl.delete();
        rst_slot = -1;
        jit_on = 1'b0;
        tick_t.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_data0", {16'h0, d0}, 32'h0);
        chk("reset_data1", {16'h0, d1}, 32'h0);
        chk("reset_data2", {8'h0, d2}, 32'h0);
        chk("reset_tick", {29'h0, t0, t1, t2}, 32'h0);
        chk("reset_err", {29'h0, e0, e1, e2}, 32'h0);

        add_frame(32'h8001_0000, 32, $urandom, 32);
        add_frame(32'h7FFE_0000, 32, $urandom, 32);
        add_frame(32'h1234_0000, 32, $urandom, 32);
        run_stream("basic");

        for (int f = 0; f < 4; f++) add_frame(32'hAAAA, 16, 32'h5555, 16);
        run_stream("stereo16");

        for (int f = 0; f < 3; f++) add_frame(32'hABCD, 16, $urandom, 16);
        run_stream("short16");

        for (int f = 0; f < 3; f++) add_frame(32'h123456, 24, $urandom, 24);
        run_stream("long24");

        for (int f = 0; f < 4; f++) add_frame($urandom, 32, $urandom, 32);
        rst_slot = 2;
        run_stream("midreset");

        for (int f = 0; f < 8; f++)
            add_frame($urandom, int'($urandom_range(32, 12)), $urandom, int'($urandom_range(32, 12)));
        run_stream("randlen");

        for (int f = 0; f < 30; f++) add_frame($urandom, 32, $urandom, 32);
        jit_on = 1'b1;
        run_stream("jitter");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
